// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO multiply/divide unit beside the EX stage: 32-step shift-add
// multiply, 32-step restoring divide, sign fix-up, and ownership of HI/LO.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             mf_req,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] mt_data,
  input  logic             abort,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             stall,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   a_q, a_d;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   q_q, q_d;      // multiplier/product-low or dividend/quotient
  logic [WIDTH-1:0]   acc_q, acc_d;  // product-high or partial remainder
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               bzero_q, bzero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  // Operand magnitudes for signed ops (MULT/DIV have op[0]==0)
  logic               signed_op;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & opa[WIDTH-1];
  assign b_neg     = signed_op & opb[WIDTH-1];
  assign mag_a     = a_neg ? -opa : opa;
  assign mag_b     = b_neg ? -opb : opb;

  // One multiply step: add multiplicand if LSB set, then shift {acc,q} right
  logic [WIDTH:0]     mul_sum;
  assign mul_sum = {1'b0, acc_q} + {1'b0, (q_q[0] ? a_q : {WIDTH{1'b0}})};

  // One restoring divide step on the WIDTH+1 bit shifted remainder
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  assign div_shift = {acc_q, q_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, a_q});
  assign div_sub   = div_shift[WIDTH-1:0] - a_q;

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod     = {acc_q, q_q};
  assign prod_fix = neg_res_q ? -prod : prod;
  assign quo_fix  = neg_res_q ? -q_q : q_q;
  assign rem_fix  = neg_rem_q ? -acc_q : acc_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    a_d        = a_q;
    q_d        = q_q;
    acc_d      = acc_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    bzero_d    = bzero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = CALC;
          is_div_d  = op[1];
          a_d       = op[1] ? mag_b : mag_a;
          q_d       = op[1] ? mag_a : mag_b;
          acc_d     = '0;
          cnt_d     = '0;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          bzero_d   = (opb == '0);
        end else if (!start) begin
          // A start on the same edge would win; MT writes only land when idle
          if (mthi_we) hi_d = mt_data;
          if (mtlo_we) lo_d = mt_data;
        end
      end

      CALC: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (is_div_q) begin
            acc_d = div_ge ? div_sub : div_shift[WIDTH-1:0];
            q_d   = {q_q[WIDTH-2:0], div_ge};
          end else begin
            acc_d = mul_sum[WIDTH:1];
            q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
          end
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
        end
      end

      FIX: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
          if (is_div_q) begin
            // Zero divisor leaves |opa| in the remainder; re-signing restores raw opa
            lo_d       = bzero_q ? {WIDTH{1'b1}} : quo_fix;
            hi_d       = rem_fix;
            div_zero_d = bzero_q;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      a_q        <= '0;
      q_q        <= '0;
      acc_q      <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      bzero_q    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      a_q        <= a_d;
      q_q        <= q_d;
      acc_q      <= acc_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      bzero_q    <= bzero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  // Handshake: a request (start/mf_req/mthi_we/mtlo_we) is accepted only when
  // stall is low; while busy the pipeline must hold it until stall drops.
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign div_zero  = div_zero_q;
  assign stall     = busy & (start | mf_req | mthi_we | mtlo_we);
  assign dbg_state = state_q;

endmodule
